// File: rtl/cic_decimator.sv
// CIC decimator front half: N cascaded integrators at the input rate, then
// keeps one sample in R. The output strobe enables the downstream comb chain.
module cic_decimator #(
  parameter int N         = 3,
  parameter int R         = 4,
  parameter int PRECISION = 12,
  parameter int GROWTH    = 6
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clr,
  input  logic                                x_valid,
  input  logic signed [PRECISION-1:0]         x,
  output logic                                y_valid,
  output logic signed [PRECISION+GROWTH-1:0]  y,
  output logic        [7:0]                   phase
);

  localparam int W = PRECISION + GROWTH;
  localparam logic [7:0] LAST_PHASE = 8'(R - 1);

  if (GROWTH < N * $clog2(R)) begin : g_bad_growth
    $error("cic_decimator: GROWTH too small for N stages at ratio R");
  end

  logic signed [W-1:0] acc_q [N];
  logic signed [W-1:0] acc_d [N];
  logic        [7:0]   phase_q, phase_d;
  logic signed [W-1:0] y_q, y_d;
  logic                y_valid_q, y_valid_d;
  logic signed [W-1:0] x_ext;

  assign x_ext = {{GROWTH{x[PRECISION-1]}}, x};

  always_comb begin
    acc_d     = acc_q;
    phase_d   = phase_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    if (clr) begin
      for (int unsigned k = 0; k < N; k++) acc_d[k] = '0;
      phase_d = '0;
    end else if (x_valid) begin
      // Every stage reads the pre-update value of its predecessor.
      acc_d[0] = acc_q[0] + x_ext;
      for (int unsigned k = 1; k < N; k++) acc_d[k] = acc_q[k] + acc_q[k-1];
      if (phase_q == LAST_PHASE) begin
        phase_d   = '0;
        y_d       = acc_d[N-1];
        y_valid_d = 1'b1;
      end else begin
        phase_d = phase_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N; k++) acc_q[k] <= '0;
      phase_q   <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < N; k++) acc_q[k] <= acc_d[k];
      phase_q   <= phase_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign phase   = phase_q;

endmodule

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
- Integrator-and-downsample front half of the CIC decimation filter.
- Runs N cascaded integrators at the input sample rate, then keeps one sample in every R.
- Output is a wide, sign-extended sample with a one-cycle valid strobe.
- Drives the comb stage chain directly. The combs are clocked, or enabled, at the decimated rate using y_valid.

Parameters:
- N, 3: number of integrator stages (1..8).
- R, 4: decimation ratio (2..256).
- PRECISION, 12: input sample width, two's complement.
- GROWTH, 6: extra register bits for bit growth. Must be at least N*ceil(log2 R), otherwise the design is illegal.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- clr, input, 1: synchronous clear of accumulators and phase counter.
- x_valid, input, 1: input sample strobe; x is consumed only when high.
- x, input, PRECISION: signed input sample.
- y_valid, output, 1: one-cycle strobe; y holds a new decimated sample.
- y, output, PRECISION+GROWTH: signed decimated output; width W = PRECISION+GROWTH.
- phase, output, 8: current decimation phase (0..R-1), for debug and alignment.

Behaviour:
- Reset: rst_n low clears immediately all accumulators acc[0..N-1], phase, y and y_valid to 0. This applies in any state, including mid-frame.
- Arithmetic:
  - All accumulators are W bits.
  - x is sign-extended to W.
  - Add is modular two's complement: wrap-around, no saturation, no overflow flag. Correct output relies on the downstream combs cancelling the wrap.
- Integrator update, only on a cycle with x_valid=1 and clr=0, all stages registered:
  - acc[0] <= acc[0] + sext(x).
  - acc[k] <= acc[k] + acc[k-1], for k=1..N-1, using the pre-update register value of acc[k-1].
  - Effective pipeline delay is one sample per stage.
- Cycles with x_valid=0: accumulators, phase and y hold; y_valid=0. Gaps of any length are legal.
- Phase counter:
  - Increments on each accepted sample.
  - Wraps R-1 -> 0.
- Decimation:
  - On an accepted sample with phase == R-1, y <= acc[N-1] + acc[N-2], i.e. the post-update value of the last integrator. For N=1 this is acc[0] + sext(x).
  - On the same edge, y_valid <= 1.
  - Latency: y and y_valid appear one clk after the R-th accepted sample.
- y_valid:
  - High for exactly one cycle per R accepted samples.
  - Never high on two consecutive cycles unless R accepted samples separate them. Not possible for R>=2, so always single-cycle.
- y holds its value between strobes.
- clr, synchronous, priority over x_valid in the same cycle:
  - acc[*] <= 0, phase <= 0, y_valid <= 0.
  - y holds its last value.
  - The sample presented in that cycle is discarded.
- Registers only, no combinational path from x to y.
- Comb interface:
  - y is stable for at least R-1 cycles after y_valid when x_valid is continuous.
  - Combs must be enabled by y_valid.

Test Plan:
- Defaults (N=3, R=4, PRECISION=12, GROWTH=6). Impulse: x=1 on the first valid cycle, then x=0 with continuous x_valid -> y_valid pulses after samples 4, 8, 12 with y = 3, 21, 55. All other cycles y_valid=0.
- Step: x=1 continuous -> y = 4, 56, 220, 560 on successive strobes. This is C(n+1,3) for n = 3, 7, 11, 15.
- Wrap: x=-2048 continuous -> y = -8192, -114688, then 73728 (-450560 mod 2^18). This confirms modular wrap, no saturation.
- Gapped input: x=1 with x_valid high every third cycle -> same y values as the step test. Strobes occur one cycle after every 4th accepted sample; phase holds across gaps.
- Mid-frame disruption:
  - Assert rst_n low asynchronously at phase=2 -> y=0, y_valid=0 and phase=0 immediately, without waiting for a clock edge.
  - After release, repeat the impulse test -> identical results.
- Clear collision: clr=1 and x_valid=1 in the same cycle at phase=3 -> no y_valid, phase=0, y holds its prior value. The subsequent impulse test matches from scratch.
